// File: rtl/frame_checker_if.sv
// rtl/frame_checker_if.sv - 16-bit ingress stream bundle for frame_checker
interface frame_checker_if;
    logic [15:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/frame_checker.sv
// rtl/frame_checker.sv - frame sink: preamble/length/tlast checks, header capture, checksum, counters
// Optional random backpressure via `define FRAME_CHECKER_STALL_EN.
module frame_checker #(
    parameter int MAX_LEN = 1500
) (
    input  logic             clk,
    input  logic             reset,
    frame_checker_if.slave   ingress_port,
    input  logic [7:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [7:0]       writedata,
    output logic [7:0]       readdata
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN} state_t;

    state_t      state;
    logic [10:0] beat;
    logic [10:0] last_idx;
    logic        len_odd;
    logic [7:0]  hdr_sh [16];
    logic [7:0]  hdr    [16];
    logic [31:0] chk_sh;
    logic [31:0] chk;
    logic [7:0]  good_cnt;
    logic [7:0]  err_cnt;
    logic        sfd_err;
    logic        len_err;
    logic        last_bad;
    logic        commit_pending;
    logic        ready_r;

    logic        good_end;
    logic        bad_end;
    logic        sfd_hit;
    logic        len_hit;

    logic        unused_wdata;
    assign unused_wdata = ^writedata;

    wire [15:0] d       = ingress_port.tdata;
    wire        tlast   = ingress_port.tlast;
    wire        accept  = ingress_port.tvalid && ingress_port.tready;
    wire [15:0] len_dec = {d[7:0], d[15:8]};
    wire        at_last = (beat == last_idx);
    wire        clr     = chipselect && write && (address == 8'd23);
    wire [2:0]  hword   = beat[2:0] - 3'd4;
    wire [31:0] chk_add = {24'd0, d[15:8]} + ((at_last && len_odd) ? 32'd0 : {24'd0, d[7:0]});

`ifdef FRAME_CHECKER_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign ingress_port.tready = ready_r & ~lfsr[0];
`else
    assign ingress_port.tready = ready_r;
`endif

    // Per-beat verdict; tlast is only legal on the beat whose index equals last_idx.
    always_comb begin
        good_end = 1'b0;
        bad_end  = 1'b0;
        sfd_hit  = 1'b0;
        len_hit  = 1'b0;
        if (accept) begin
            case (state)
                IDLE, PREAMBLE: begin
                    if (d != ((state == PREAMBLE && beat == 11'd3) ? 16'hAAAB : 16'hAAAA)) sfd_hit = 1'b1;
                    if (tlast) begin len_hit = 1'b1; bad_end = 1'b1; end
                end
                HEADER: begin
                    if (beat == 11'd10 && 32'(len_dec) > MAX_LEN) len_hit = 1'b1;
                    if (tlast) begin
                        if (beat == 11'd11 && last_idx == 11'd11) good_end = 1'b1;
                        else begin len_hit = 1'b1; bad_end = 1'b1; end
                    end else if (beat == 11'd11 && last_idx == 11'd11) begin
                        len_hit = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (tlast) begin
                        if (at_last) good_end = 1'b1;
                        else begin len_hit = 1'b1; bad_end = 1'b1; end
                    end else if (at_last) begin
                        len_hit = 1'b1;
                    end
                end
                DRAIN: if (tlast) bad_end = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            beat           <= '0;
            last_idx       <= '0;
            len_odd        <= 1'b0;
            chk_sh         <= '0;
            chk            <= '0;
            good_cnt       <= '0;
            err_cnt        <= '0;
            sfd_err        <= 1'b0;
            len_err        <= 1'b0;
            last_bad       <= 1'b0;
            commit_pending <= 1'b0;
            ready_r        <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                hdr_sh[i] <= '0;
                hdr[i]    <= '0;
            end
        end else begin
            ready_r <= 1'b1;
            if (accept) begin
                case (state)
                    IDLE: begin
                        beat   <= 11'd1;
                        chk_sh <= '0;
                        if (bad_end)      state <= IDLE;
                        else if (sfd_hit) state <= DRAIN;
                        else              state <= PREAMBLE;
                    end
                    PREAMBLE: begin
                        beat <= beat + 11'd1;
                        if (bad_end)               state <= IDLE;
                        else if (sfd_hit)          state <= DRAIN;
                        else if (beat == 11'd3)    state <= HEADER;
                    end
                    HEADER: begin
                        beat <= beat + 11'd1;
                        hdr_sh[{hword, 1'b0}] <= d[15:8];
                        hdr_sh[{hword, 1'b1}] <= d[7:0];
                        if (beat == 11'd10) begin
                            last_idx <= 11'd11 + 11'((len_dec + 16'd1) >> 1);
                            len_odd  <= len_dec[0];
                        end
                        if (good_end || bad_end)   state <= IDLE;
                        else if (len_hit)          state <= DRAIN;
                        else if (beat == 11'd11)   state <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        beat   <= beat + 11'd1;
                        chk_sh <= chk_sh + chk_add;
                        if (good_end || bad_end)   state <= IDLE;
                        else if (len_hit)          state <= DRAIN;
                    end
                    DRAIN: if (tlast) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            // Copy one cycle after the good tlast so the final beat's data is in the shadows.
            commit_pending <= good_end;
            if (commit_pending) begin
                chk <= chk_sh;
                for (int i = 0; i < 16; i++) hdr[i] <= hdr_sh[i];
            end

            if (good_end) begin
                good_cnt <= (good_cnt == 8'hFF) ? good_cnt : good_cnt + 8'd1;
                last_bad <= 1'b0;
            end
            if (bad_end) begin
                err_cnt  <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                last_bad <= 1'b1;
            end
            if (sfd_hit) sfd_err <= 1'b1;
            if (len_hit) len_err <= 1'b1;

            if (clr) begin
                good_cnt <= '0;
                err_cnt  <= '0;
                sfd_err  <= 1'b0;
                len_err  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !(chipselect && read)) begin
            readdata <= '0;
        end else if (address < 8'd16) begin
            readdata <= hdr[address[3:0]];
        end else begin
            case (address)
                8'd16:   readdata <= chk[7:0];
                8'd17:   readdata <= chk[15:8];
                8'd18:   readdata <= chk[23:16];
                8'd19:   readdata <= chk[31:24];
                8'd20:   readdata <= good_cnt;
                8'd21:   readdata <= err_cnt;
                8'd22:   readdata <= {4'b0, state != IDLE, len_err, sfd_err, last_bad};
                default: readdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_checker.sv
// tb/tb_frame_checker.sv - directed, table-driven bench for frame_checker
module tb_frame_checker;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic       chipselect;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;

    always #5 clk = ~clk;

    frame_checker_if ingress_port ();

    frame_checker dut (
        .clk          (clk),
        .reset        (reset),
        .ingress_port (ingress_port),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] frm[$];
    rd_vec_t     tbl[$];
    logic [7:0]  v;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d, input logic l, input logic clr);
        int n = 0;
        @(negedge clk);
        ingress_port.tdata  = d;
        ingress_port.tlast  = l;
        ingress_port.tvalid = 1'b1;
        while (ingress_port.tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL tready_timeout: got stalled expected accept");
        end
        if (clr) begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 8'd23;
        end
        @(posedge clk);
        #1;
        ingress_port.tvalid = 1'b0;
        ingress_port.tlast  = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic send_frm(input int last_at, input int clr_at);
        for (int i = 0; i < frm.size(); i++) beat(frm[i], i == last_at, i == clr_at);
    endtask

    task automatic mk_hdr(input logic [15:0] tag, input logic [15:0] len);
        frm.delete();
        repeat (3) frm.push_back(16'hAAAA);
        frm.push_back(16'hAAAB);
        frm.push_back(16'h0102 + tag);
        frm.push_back(16'h0304 + tag);
        frm.push_back(16'h0506 + tag);
        frm.push_back(16'h1112);
        frm.push_back(16'h1314);
        frm.push_back(16'h1516);
        frm.push_back({len[7:0], len[15:8]});
        frm.push_back(16'h0800);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] data);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(posedge clk);
        #1;
        data       = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic wr_clear();
        @(negedge clk);
        address    = 8'd23;
        writedata  = 8'h5A;
        chipselect = 1'b1;
        write      = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] r;
        rd(a, r);
        check(nm, {24'd0, r}, {24'd0, exp});
    endtask

    task automatic good4();
        mk_hdr(16'h0000, 16'd4);
        frm.push_back(16'h0102);
        frm.push_back(16'h0304);
        send_frm(13, -1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) tbl.push_back('{8'(i), 8'(i + 1)});
        for (int i = 0; i < 6; i++) tbl.push_back('{8'(6 + i), 8'(8'h11 + i)});
        tbl.push_back('{8'd12, 8'h04});
        tbl.push_back('{8'd13, 8'h00});
        tbl.push_back('{8'd14, 8'h08});
        tbl.push_back('{8'd15, 8'h00});
        tbl.push_back('{8'd16, 8'h0A});
        tbl.push_back('{8'd17, 8'h00});
        tbl.push_back('{8'd18, 8'h00});
        tbl.push_back('{8'd19, 8'h00});
        tbl.push_back('{8'd20, 8'h01});
        tbl.push_back('{8'd21, 8'h00});
        tbl.push_back('{8'd22, 8'h00});
        tbl.push_back('{8'd23, 8'h00});
        tbl.push_back('{8'd200, 8'h00});

        ingress_port.tdata  = '0;
        ingress_port.tlast  = 1'b0;
        ingress_port.tvalid = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tready", {31'd0, ingress_port.tready}, 32'd0);
        check("reset_readdata", {24'd0, readdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("reset_status", 8'd22, 8'h00);
        rd_chk("reset_good", 8'd20, 8'h00);

        good4();
        for (int i = 0; i < tbl.size(); i++) begin
            rd(tbl[i].addr, v);
            check($sformatf("reg%0d", tbl[i].addr), {24'd0, v}, {24'd0, tbl[i].exp});
        end
        @(posedge clk);
        #1;
        check("readdata_idle", {24'd0, readdata}, 32'd0);

        mk_hdr(16'h0000, 16'd3);
        frm.push_back(16'h0A0B);
        frm.push_back(16'h0CFF);
        send_frm(13, -1);
        repeat (3) @(posedge clk);
        rd_chk("odd_chk", 8'd16, 8'h21);
        rd_chk("odd_len12", 8'd12, 8'h03);
        rd_chk("odd_good", 8'd20, 8'h02);

        frm.delete();
        repeat (4) frm.push_back(16'hAAAA);
        for (int i = 0; i < 5; i++) frm.push_back(16'h1234);
        send_frm(8, -1);
        repeat (2) @(posedge clk);
        rd_chk("sfd_status", 8'd22, 8'h03);
        rd_chk("sfd_err_cnt", 8'd21, 8'h01);
        good4();
        rd_chk("sfd_next_good", 8'd20, 8'h03);
        rd_chk("sfd_next_status", 8'd22, 8'h02);

        wr_clear();
        rd_chk("clear_good", 8'd20, 8'h00);
        mk_hdr(16'h8080, 16'd4);
        frm.push_back(16'h1111);
        send_frm(12, -1);
        mk_hdr(16'h8080, 16'd4);
        frm.push_back(16'h2222);
        frm.push_back(16'h3333);
        frm.push_back(16'h4444);
        send_frm(14, -1);
        repeat (3) @(posedge clk);
        rd_chk("len_err_cnt", 8'd21, 8'h02);
        rd_chk("len_status", 8'd22, 8'h05);
        rd_chk("len_keep_reg0", 8'd0, 8'h01);
        rd_chk("len_keep_chk", 8'd16, 8'h0A);

        mk_hdr(16'h0000, 16'd0);
        send_frm(11, 11);
        repeat (3) @(posedge clk);
        rd_chk("len0_clear_good", 8'd20, 8'h00);
        rd_chk("len0_err", 8'd21, 8'h00);
        rd_chk("len0_chk", 8'd16, 8'h00);
        rd_chk("len0_reg12", 8'd12, 8'h00);
        rd_chk("len0_status", 8'd22, 8'h00);

        good4();
        mk_hdr(16'h0000, 16'd4);
        for (int i = 0; i < 7; i++) beat(frm[i], 1'b0, 1'b0);
        rd_chk("mid_busy", 8'd22, 8'h08);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_tready", {31'd0, ingress_port.tready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("mid_good", 8'd20, 8'h00);
        rd_chk("mid_err", 8'd21, 8'h00);
        rd_chk("mid_status", 8'd22, 8'h00);
        rd_chk("mid_chk", 8'd16, 8'h00);
        good4();
        rd_chk("after_reset_good", 8'd20, 8'h01);
        rd_chk("after_reset_chk", 8'd16, 8'h0A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
